// File: rtl/dma_pkg.sv
// Shared definitions for the DMA engines: CPU command codes, the DRAM address
// layout and the write-back FSM state encoding.
package dma_pkg;

    localparam logic [7:0] CPU_RD_CMD      = 8'h30;
    localparam logic [7:0] CPU_WB_CMD      = 8'h31;

    localparam logic [9:0] DRAM_ADR_PREFIX = 10'h1E0;
    localparam logic [1:0] DRAM_ADR_REGION = 2'd2;

    localparam int         ADDR_STRIDE     = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_DATA = 2'd1,
        WRITE     = 2'd2,
        DONE      = 2'd3
    } wb_state_e;

    // Full DRAM byte address for an 8-bit word address inside the DMA window.
    function automatic logic [31:0] dram_word_addr(input logic [7:0] word_addr);
        return {DRAM_ADR_PREFIX, 12'd0, DRAM_ADR_REGION, word_addr};
    endfunction

endpackage

// File: rtl/dma_writeback_fifo.sv
// Result FIFO for the write-back DMA. First-word-fall-through head; full and
// empty are registered so the accelerator-side ready never depends on a pop in
// the same cycle.
module dma_wr_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  do_push, do_pop;

    // Pointer/count update; flags are computed from the next count so they
    // are valid straight out of the flops.
    always_comb begin
        do_push  = push & ~full_q;
        do_pop   = pop & ~empty_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        full_d  = (count_d == CNT_W'(DEPTH));
        empty_d = (count_d == '0);
    end

    // Control state; reset flushes the FIFO.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage array; contents need no reset because empty gates every read.
    always_ff @(posedge wb_clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    assign data_out = mem_q[rd_ptr_q];
    assign full     = full_q;
    assign empty    = empty_q;

endmodule

// File: rtl/dma_writeback.sv
// Write-back DMA: buffers accelerator results and writes them to DRAM as
// single-word Wishbone writes over a CPU-programmed word-address range.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   IDLE      | no command; results may still be buffered in the FIFO
//   WAIT_DATA | range active, waiting for a result word in the FIFO
//   WRITE     | DRAM write cycle open, holding cyc/stb/adr/dat until ack
//   DONE      | last word acknowledged; done_o high for this one cycle
module dma_writeback
    import dma_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int INS_ADDR   = 8
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  cpu_wbs_stb_i,
    input  logic                  cpu_wbs_cyc_i,
    input  logic                  cpu_wbs_we_i,
    input  logic [3:0]            cpu_wbs_sel_i,
    input  logic [31:0]           cpu_wbs_dat_i,
    input  logic [31:0]           cpu_wbs_adr_i,
    input  logic                  acc_res_valid_i,
    input  logic [DATA_WIDTH-1:0] acc_res_data_i,
    output logic                  acc_res_ready_o,
    output logic                  dram_wbs_cyc_i,
    output logic                  dram_wbs_stb_i,
    output logic                  dram_wbs_we_i,
    output logic [3:0]            dram_wbs_sel_i,
    output logic [31:0]           dram_wbs_adr_i,
    output logic [DATA_WIDTH-1:0] dram_wbs_dat_i,
    input  logic                  dram_wbs_ack_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  cmd_drop_o
);

    wb_state_e             state_q, state_d;
    logic [INS_ADDR-1:0]   cur_addr_q, cur_addr_d;
    logic [INS_ADDR-1:0]   end_addr_q, end_addr_d;
    logic                  cyc_q, cyc_d;
    logic                  stb_q, stb_d;
    logic                  we_q, we_d;
    logic [3:0]            sel_q, sel_d;
    logic [31:0]           adr_q, adr_d;
    logic [DATA_WIDTH-1:0] dat_q, dat_d;
    logic                  done_q, done_d;
    logic                  drop_q, drop_d;

    logic                  cmd;
    logic                  last_word;
    logic                  fifo_push, fifo_pop;
    logic                  fifo_full, fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_head;

    // The CPU-side decoder owns the ack, so byte selects and the low address
    // bits play no part here.
    logic unused_cpu_bits;
    assign unused_cpu_bits = ^{cpu_wbs_sel_i, cpu_wbs_dat_i[31:16], cpu_wbs_adr_i[23:0]};

    assign cmd = cpu_wbs_cyc_i & cpu_wbs_stb_i & cpu_wbs_we_i &
                 (cpu_wbs_adr_i[31:24] == CPU_WB_CMD);

    // Ready is held low during reset so every output reads zero there.
    assign acc_res_ready_o = ~fifo_full & ~wb_rst_i;
    assign fifo_push       = acc_res_valid_i & acc_res_ready_o;

    dma_wr_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .push     (fifo_push),
        .pop      (fifo_pop),
        .data_in  (acc_res_data_i),
        .data_out (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Only the word-index bits decide termination; the low bits ride along
    // from the base address.
    assign last_word = (cur_addr_q[INS_ADDR-1:2] == end_addr_q[INS_ADDR-1:2]);

    // Next-state and next-output logic for the transfer FSM.
    always_comb begin
        state_d    = state_q;
        cur_addr_d = cur_addr_q;
        end_addr_d = end_addr_q;
        cyc_d      = cyc_q;
        stb_d      = stb_q;
        we_d       = we_q;
        sel_d      = sel_q;
        adr_d      = adr_q;
        dat_d      = dat_q;
        done_d     = 1'b0;
        drop_d     = cmd & (state_q != IDLE);
        fifo_pop   = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd) begin
                    cur_addr_d = INS_ADDR'(cpu_wbs_dat_i[15:8]);
                    end_addr_d = INS_ADDR'(cpu_wbs_dat_i[7:0]);
                    state_d    = WAIT_DATA;
                end
            end
            WAIT_DATA: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    dat_d    = fifo_head;
                    cyc_d    = 1'b1;
                    stb_d    = 1'b1;
                    we_d     = 1'b1;
                    sel_d    = 4'hF;
                    adr_d    = dram_word_addr(8'(cur_addr_q));
                    state_d  = WRITE;
                end
            end
            WRITE: begin
                if (dram_wbs_ack_o) begin
                    cyc_d = 1'b0;
                    stb_d = 1'b0;
                    we_d  = 1'b0;
                    sel_d = 4'h0;
                    adr_d = '0;
                    if (last_word) begin
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        cur_addr_d = cur_addr_q + INS_ADDR'(ADDR_STRIDE);
                        state_d    = WAIT_DATA;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM and registered outputs; reset abandons any open DRAM cycle at once.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q    <= IDLE;
            cur_addr_q <= '0;
            end_addr_q <= '0;
            cyc_q      <= 1'b0;
            stb_q      <= 1'b0;
            we_q       <= 1'b0;
            sel_q      <= 4'h0;
            adr_q      <= '0;
            dat_q      <= '0;
            done_q     <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_addr_q <= cur_addr_d;
            end_addr_q <= end_addr_d;
            cyc_q      <= cyc_d;
            stb_q      <= stb_d;
            we_q       <= we_d;
            sel_q      <= sel_d;
            adr_q      <= adr_d;
            dat_q      <= dat_d;
            done_q     <= done_d;
            drop_q     <= drop_d;
        end
    end

    assign dram_wbs_cyc_i = cyc_q;
    assign dram_wbs_stb_i = stb_q;
    assign dram_wbs_we_i  = we_q;
    assign dram_wbs_sel_i = sel_q;
    assign dram_wbs_adr_i = adr_q;
    assign dram_wbs_dat_i = dat_q;
    assign busy_o         = (state_q != IDLE);
    assign done_o         = done_q;
    assign cmd_drop_o     = drop_q;

endmodule

// File: tb/tb_dma_writeback.sv
// Bench for dma_writeback: directed scenarios plus randomized ranges, checked
// against a queue-based model of the expected DRAM write stream.
module tb_dma_writeback;

    localparam int DEPTH = 4;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic        cpu_wbs_stb_i = 1'b0;
    logic        cpu_wbs_cyc_i = 1'b0;
    logic        cpu_wbs_we_i = 1'b0;
    logic [3:0]  cpu_wbs_sel_i = 4'h0;
    logic [31:0] cpu_wbs_dat_i = 32'h0;
    logic [31:0] cpu_wbs_adr_i = 32'h0;
    logic        acc_res_valid_i = 1'b0;
    logic [31:0] acc_res_data_i = 32'h0;
    logic        acc_res_ready_o;
    logic        dram_wbs_cyc_i;
    logic        dram_wbs_stb_i;
    logic        dram_wbs_we_i;
    logic [3:0]  dram_wbs_sel_i;
    logic [31:0] dram_wbs_adr_i;
    logic [31:0] dram_wbs_dat_i;
    logic        dram_wbs_ack_o;
    logic        busy_o;
    logic        done_o;
    logic        cmd_drop_o;

    dma_writeback dut (
        .wb_clk_i        (wb_clk_i),
        .wb_rst_i        (wb_rst_i),
        .cpu_wbs_stb_i   (cpu_wbs_stb_i),
        .cpu_wbs_cyc_i   (cpu_wbs_cyc_i),
        .cpu_wbs_we_i    (cpu_wbs_we_i),
        .cpu_wbs_sel_i   (cpu_wbs_sel_i),
        .cpu_wbs_dat_i   (cpu_wbs_dat_i),
        .cpu_wbs_adr_i   (cpu_wbs_adr_i),
        .acc_res_valid_i (acc_res_valid_i),
        .acc_res_data_i  (acc_res_data_i),
        .acc_res_ready_o (acc_res_ready_o),
        .dram_wbs_cyc_i  (dram_wbs_cyc_i),
        .dram_wbs_stb_i  (dram_wbs_stb_i),
        .dram_wbs_we_i   (dram_wbs_we_i),
        .dram_wbs_sel_i  (dram_wbs_sel_i),
        .dram_wbs_adr_i  (dram_wbs_adr_i),
        .dram_wbs_dat_i  (dram_wbs_dat_i),
        .dram_wbs_ack_o  (dram_wbs_ack_o),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .cmd_drop_o      (cmd_drop_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Model state: words waiting to be offered, words held in the FIFO, and
    // DRAM addresses still owed by accepted commands.
    logic [31:0] feed_q[$];
    logic [31:0] model_q[$];
    logic [31:0] exp_adr_q[$];

    bit   feed_gaps = 0;
    logic acc_take  = 1'b0;
    bit   rand_ack  = 0;
    int   ack_delay = 0;
    logic slave_ack = 1'b0;
    logic stray_ack = 1'b0;
    bit   in_cyc    = 0;
    int   wait_cnt  = 0;
    int   cur_delay = 0;
    logic [31:0] hold_adr, hold_dat;
    int   done_cnt  = 0;
    int   drop_cnt  = 0;
    logic prev_done = 1'b0;
    int   exp_done  = 0;

    assign dram_wbs_ack_o = slave_ack | stray_ack;

    // Accelerator side: offer the head of feed_q, optionally with random gaps.
    always @(negedge wb_clk_i) begin
        if (!wb_rst_i && feed_q.size() > 0 && (!feed_gaps || $urandom_range(0, 3) != 0)) begin
            acc_res_valid_i = 1'b1;
            acc_res_data_i  = feed_q[0];
            acc_take        = acc_res_ready_o;
        end else begin
            acc_res_valid_i = 1'b0;
            acc_take        = 1'b0;
        end
    end

    always @(posedge wb_clk_i) begin
        if (acc_take && !wb_rst_i && feed_q.size() > 0) begin
            model_q.push_back(feed_q.pop_front());
        end
    end

    // DRAM slave: checks each write against the model, holds ack off for the
    // chosen delay, and checks idle-bus values and FIFO back-pressure.
    always @(negedge wb_clk_i) begin
        if (wb_rst_i) begin
            slave_ack = 1'b0;
            in_cyc    = 0;
        end else if (slave_ack) begin
            slave_ack = 1'b0;
            in_cyc    = 0;
            chk("cyc_low_after_ack", dram_wbs_cyc_i, 0);
        end else if (dram_wbs_cyc_i) begin
            if (!in_cyc) begin
                in_cyc    = 1;
                wait_cnt  = 0;
                cur_delay = rand_ack ? int'($urandom_range(0, 3)) : ack_delay;
                hold_adr  = dram_wbs_adr_i;
                hold_dat  = dram_wbs_dat_i;
                chk("write_expected", exp_adr_q.size() > 0, 1);
                if (exp_adr_q.size() > 0) chk("write_adr", dram_wbs_adr_i, exp_adr_q.pop_front());
                chk("write_has_data", model_q.size() > 0, 1);
                if (model_q.size() > 0) chk("write_dat", dram_wbs_dat_i, model_q.pop_front());
                chk("write_ctl", {dram_wbs_stb_i, dram_wbs_we_i, dram_wbs_sel_i}, 6'h3F);
            end else begin
                chk("hold_adr", dram_wbs_adr_i, hold_adr);
                chk("hold_dat", dram_wbs_dat_i, hold_dat);
                chk("hold_ctl", {dram_wbs_stb_i, dram_wbs_we_i, dram_wbs_sel_i}, 6'h3F);
            end
            if (wait_cnt >= cur_delay) slave_ack = 1'b1;
            else wait_cnt++;
        end else begin
            chk("idle_adr", dram_wbs_adr_i, 0);
            chk("idle_ctl", {dram_wbs_stb_i, dram_wbs_we_i, dram_wbs_sel_i}, 0);
        end
        if (!wb_rst_i) chk("ready_vs_fill", acc_res_ready_o, model_q.size() < DEPTH);
    end

    always @(negedge wb_clk_i) begin
        if (done_o) begin
            done_cnt++;
            chk("done_single_cycle", prev_done, 0);
        end
        prev_done = done_o;
        if (cmd_drop_o) drop_cnt++;
    end

    task automatic send_cmd(input logic [7:0] top, input logic [7:0] base, input logic [7:0] endv,
                            input bit start, input bit drop, input bit busy);
        logic [31:0] r;
        int n;
        r = $urandom;
        @(negedge wb_clk_i);
        cpu_wbs_cyc_i = 1'b1;
        cpu_wbs_stb_i = 1'b1;
        cpu_wbs_we_i  = 1'b1;
        cpu_wbs_sel_i = r[3:0];
        cpu_wbs_adr_i = {top, r[23:0]};
        cpu_wbs_dat_i = {r[31:16], base, endv};
        if (start) begin
            n = ((int'(endv >> 2) - int'(base >> 2)) & 63) + 1;
            for (int i = 0; i < n; i++) exp_adr_q.push_back(32'h7800_0200 | ((int'(base) + 4 * i) & 255));
            exp_done++;
        end
        @(negedge wb_clk_i);
        cpu_wbs_cyc_i = 1'b0;
        cpu_wbs_stb_i = 1'b0;
        cpu_wbs_we_i  = 1'b0;
        chk("cmd_drop", cmd_drop_o, drop);
        chk("cmd_busy", busy_o, busy);
    endtask

    task automatic wait_done(input int budget);
        bit seen = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge wb_clk_i);
            if (done_o) begin
                seen = 1;
                break;
            end
        end
        chk("done_seen", seen, 1);
        if (seen) begin
            chk("busy_in_done", busy_o, 1);
            chk("writes_outstanding", exp_adr_q.size(), 0);
            @(negedge wb_clk_i);
            chk("done_fell", done_o, 0);
            chk("busy_fell", busy_o, 0);
        end
    endtask

    task automatic wait_fed(input int budget);
        for (int i = 0; i < budget && feed_q.size() > 0; i++) @(negedge wb_clk_i);
        chk("feed_drained", feed_q.size(), 0);
    endtask

    task automatic wait_cyc(input int budget);
        for (int i = 0; i < budget && !dram_wbs_cyc_i; i++) @(negedge wb_clk_i);
        chk("write_started", dram_wbs_cyc_i, 1);
    endtask

    initial begin
        logic [7:0] base, endv;
        int k;

        // Reset state
        repeat (2) @(negedge wb_clk_i);
        chk("rst_dram_ctl", {dram_wbs_cyc_i, dram_wbs_stb_i, dram_wbs_we_i, dram_wbs_sel_i}, 0);
        chk("rst_dram_adr", dram_wbs_adr_i, 0);
        chk("rst_status", {busy_o, done_o, cmd_drop_o, acc_res_ready_o}, 0);
        wb_rst_i = 1'b0;

        // 1: preloaded results, three-word range
        feed_q.push_back(32'hA0);
        feed_q.push_back(32'hA1);
        feed_q.push_back(32'hA2);
        wait_fed(10);
        send_cmd(8'h31, 8'h10, 8'h18, 1, 0, 1);
        wait_done(50);

        // A read-DMA command code must not start this engine
        send_cmd(8'h30, 8'h10, 8'h18, 0, 0, 0);

        // 2: single word, data arrives late; a stray ack in WAIT_DATA is ignored
        send_cmd(8'h31, 8'h20, 8'h20, 1, 0, 1);
        repeat (3) @(negedge wb_clk_i);
        stray_ack = 1'b1;
        @(negedge wb_clk_i);
        stray_ack = 1'b0;
        repeat (5) @(negedge wb_clk_i);
        chk("waiting_no_write", {busy_o, dram_wbs_stb_i}, 2'b10);
        @(posedge wb_clk_i);
        #1 feed_q.push_back(32'hDEAD_BEEF);
        @(posedge wb_clk_i);
        #1;
        @(negedge wb_clk_i);
        chk("stb_not_yet", dram_wbs_stb_i, 0);
        @(negedge wb_clk_i);
        chk("stb_after_push", dram_wbs_stb_i, 1);
        wait_done(20);

        // 3: range wrapping through 0xFC to 0x00
        for (int i = 0; i < 4; i++) feed_q.push_back($urandom);
        send_cmd(8'h31, 8'hF8, 8'h04, 1, 0, 1);
        wait_done(80);

        // 4: slow ack, dropped command mid-write, FIFO fills behind the stall
        ack_delay = 5;
        feed_q.push_back(32'h4444_0001);
        wait_fed(10);
        send_cmd(8'h31, 8'h40, 8'h44, 1, 0, 1);
        wait_cyc(10);
        for (int i = 0; i < 4; i++) feed_q.push_back(32'h5555_0000 + i);
        send_cmd(8'h31, 8'h80, 8'h90, 0, 1, 1);
        @(negedge wb_clk_i);
        chk("drop_pulse_ended", cmd_drop_o, 0);
        wait_fed(10);
        chk("ready_low_full", acc_res_ready_o, 0);
        chk("still_stalled", dram_wbs_cyc_i, 1);
        wait_done(60);
        ack_delay = 0;

        // Randomized ranges, gaps and ack delays
        rand_ack  = 1;
        feed_gaps = 1;
        for (int t = 0; t < 6; t++) begin
            base = 8'($urandom);
            k    = $urandom_range(0, 9);
            endv = 8'(((int'(base) & 8'hFC) + 4 * k) & 8'hFC) | 8'($urandom_range(0, 3));
            for (int i = 0; i <= k + int'($urandom_range(0, 1)); i++) feed_q.push_back($urandom);
            send_cmd(8'h31, base, endv, 1, 0, 1);
            wait_done(400);
        end
        rand_ack  = 0;
        feed_gaps = 0;

        // 5: reset during a write, then a fresh command
        ack_delay = 20;
        for (int i = 0; i < 3; i++) feed_q.push_back($urandom);
        send_cmd(8'h31, 8'h60, 8'h68, 1, 0, 1);
        wait_cyc(30);
        @(negedge wb_clk_i);
        wb_rst_i = 1'b1;
        feed_q.delete();
        model_q.delete();
        exp_adr_q.delete();
        exp_done--;
        #1;
        chk("rst_mid_ctl", {dram_wbs_cyc_i, dram_wbs_stb_i, dram_wbs_we_i, dram_wbs_sel_i}, 0);
        chk("rst_mid_status", {busy_o, done_o}, 0);
        repeat (2) @(negedge wb_clk_i);
        wb_rst_i  = 1'b0;
        ack_delay = 0;
        send_cmd(8'h31, 8'h60, 8'h64, 1, 0, 1);
        repeat (4) @(negedge wb_clk_i);
        chk("fifo_flushed", {busy_o, dram_wbs_cyc_i}, 2'b10);
        feed_q.push_back(32'h6000_0000);
        feed_q.push_back(32'h6000_0001);
        wait_done(40);

        repeat (2) @(negedge wb_clk_i);
        chk("done_count", done_cnt, exp_done);
        chk("drop_count", drop_cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dma_writeback.md
Name: dma_writeback

Overview:
Write-back DMA engine. It takes result words from the accelerator over a valid/ready stream and buffers them in a small FIFO. It then writes them into DRAM as single-word Wishbone write cycles, over an address range programmed by a CPU Wishbone write. It is the DRAM-writing counterpart of the read DMA and uses the same DRAM master port style, so a DRAM arbiter can mux the two.

Parameters:
DATA_WIDTH, 32, accelerator/DRAM data width
DEPTH, 4, result FIFO entries (power of two, >=2)
INS_ADDR, 8, width of base/end word-address fields

Ports:
wb_clk_i  in  1  clock
wb_rst_i  in  1  reset, asynchronous, active-high
cpu_wbs_stb_i  in  1  CPU Wishbone strobe
cpu_wbs_cyc_i  in  1  CPU Wishbone cycle
cpu_wbs_we_i  in  1  CPU write enable
cpu_wbs_sel_i  in  4  byte selects (ignored)
cpu_wbs_dat_i  in  32  command data: [15:8]=base, [7:0]=end
cpu_wbs_adr_i  in  32  CPU address; [31:24]==8'h31 selects this block
acc_res_valid_i  in  1  accelerator result valid
acc_res_data_i  in  32  accelerator result word
acc_res_ready_o  out  1  FIFO can accept (= !full)
dram_wbs_cyc_i  out  1  DRAM Wishbone cycle
dram_wbs_stb_i  out  1  DRAM Wishbone strobe
dram_wbs_we_i  out  1  always 1 while cyc asserted
dram_wbs_sel_i  out  4  4'hF while cyc asserted, else 0
dram_wbs_adr_i  out  32  {10'h1E0, 12'd0, 2'd2, cur_addr}
dram_wbs_dat_i  out  32  write data
dram_wbs_ack_o  in  1  DRAM acknowledge
busy_o  out  1  command active (state != IDLE)
done_o  out  1  one-cycle pulse at end of range
cmd_drop_o  out  1  one-cycle pulse: command arrived while busy

Behaviour:
- Command decode: cmd = cpu_wbs_cyc_i & cpu_wbs_stb_i & cpu_wbs_we_i & (cpu_wbs_adr_i[31:24]==8'h31).
  - This block never drives the CPU ack; the CPU-side decoder acks.
- Reset: every output is 0; the FIFO is flushed; state = IDLE. Reset mid-transfer abandons the transfer immediately. cyc/stb drop asynchronously, with no completion of the cycle.
- All DRAM outputs are registered.
- FSM states:
  - IDLE:
    - On cmd: cur_addr <= dat[15:8], end_addr <= dat[7:0] -> WAIT_DATA.
  - WAIT_DATA:
    - If FIFO not empty: pop head into dram_wbs_dat_i; cyc/stb/we <= 1; sel <= 4'hF -> WRITE.
    - Else stay.
  - WRITE:
    - Hold cyc/stb/we/sel/adr/dat stable until dram_wbs_ack_o=1.
    - On the ack cycle: clear cyc/stb/we/sel (low the next cycle).
    - If cur_addr[7:2]==end_addr[7:2] -> DONE; else cur_addr <= cur_addr+4 (mod 256) -> WAIT_DATA.
  - DONE: done_o=1 for exactly one cycle -> IDLE.
- Address rules:
  - Termination compares bits [7:2] only; bits [1:0] of cur_addr come from base.
  - Word count = ((end[7:2]-base[7:2]) mod 64) + 1.
  - end < base wraps through 0xFC to 0x00. base == end transfers exactly one word.
- Latency: cmd sampled at edge N gives WAIT_DATA at N+1. With the FIFO non-empty, stb is high from N+2. After an ack, the next stb rises at the earliest 2 cycles after the ack cycle (one idle cycle between writes).
- ack while not in WRITE is ignored.
- A cmd in any non-IDLE state is dropped: cmd_drop_o pulses, and cur/end are untouched.
- FIFO push: acc_res_valid_i & acc_res_ready_o, accepted in any state, including IDLE.
  - Data pushed before a command is written by that command.
  - Words left over after DONE stay for the next command.
- FIFO boundaries:
  - ready is derived from the registered full flag, so a pop does not free space in the same cycle.
  - Push into an empty FIFO is visible to WAIT_DATA one cycle later.
  - Simultaneous push and pop when neither full nor empty keeps the count unchanged.
- dram_wbs_adr_i reads 32'd0 when cyc is low.

Decomposition:
- Shared package dma_pkg:
  - command codes CPU_RD_CMD=8'h30, CPU_WB_CMD=8'h31
  - DRAM address prefix (10'h1E0, 2'd2)
  - address stride 4
  - state encoding IDLE/WAIT_DATA/WRITE/DONE
- One sub-module dma_wr_fifo: synchronous FIFO with registered full/empty and a first-word-fall-through head (push, pop, data_in, data_out, full, empty).

Test Plan:
1. Preload results 0xA0,0xA1,0xA2; cmd dat=0x0000_1018 -> three DRAM writes to adr 0x7800_0210/214/218 with data A0/A1/A2; done_o pulses once; busy_o falls afterwards.
2. Cmd base=0x20 end=0x20, no data; push 0xDEAD_BEEF 10 cycles later -> one write to 0x7800_0220, stb rising 2 cycles after the push, then done_o.
3. Cmd base=0xF8 end=0x04, 4 results -> writes to 0xF8, 0xFC, 0x00, 0x04 (low byte); then done.
4. DRAM ack delayed 5 cycles -> cyc/stb/adr/dat stable throughout; a second cmd mid-write -> cmd_drop_o pulse, range unchanged; acc_res_ready_o=0 after 4 more pushes (DEPTH=4).
5. Assert wb_rst_i during WRITE -> cyc/stb/we/sel, busy_o and done_o all 0 immediately; FIFO empty; a fresh cmd afterwards works normally.
